// File: rtl/control_unit_pkg.sv
// Shared ISA opcodes and control-signal encodings for the control unit and its decoder.
package control_unit_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic {
        ADDR_ALU = 1'b0,
        ADDR_PC  = 1'b1
    } addr_sel_t;

    typedef enum logic [1:0] {
        RD_ALU = 2'b00,
        RD_MEM = 2'b01,
        RD_CSR = 2'b10,
        RD_NPC = 2'b11
    } rd_sel_t;

    typedef enum logic [1:0] {
        ALU1_RS = 2'b00,
        ALU1_PC = 2'b01,
        ALU1_ZR = 2'b10
    } alu1_sel_t;

    typedef enum logic [1:0] {
        ALU2_RS = 2'b00,
        ALU2_IM = 2'b01,
        ALU2_IS = 2'b10
    } alu2_sel_t;

    typedef enum logic [3:0] {
        CLS_OP       = 4'd0,
        CLS_OPIMM    = 4'd1,
        CLS_OPIMM_SH = 4'd2,
        CLS_LUI      = 4'd3,
        CLS_AUIPC    = 4'd4,
        CLS_JAL      = 4'd5,
        CLS_JALR     = 4'd6,
        CLS_BRANCH   = 4'd7,
        CLS_LOAD     = 4'd8,
        CLS_STORE    = 4'd9,
        CLS_FENCE    = 4'd10,
        CLS_CSR      = 4'd11,
        CLS_ILLEGAL  = 4'd12
    } iclass_t;

    // Shift-immediate forms take the short shamt operand instead of the full immediate.
    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

    function automatic logic is_halting_system_f3(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b100);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier: maps opcode/funct3 to an instruction class.
module control_decode
    import control_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    output iclass_t    iclass,
    output logic       illegal
);

    // Classify the instruction; anything unrecognised falls to CLS_ILLEGAL.
    always_comb begin
        iclass = CLS_ILLEGAL;
        if (opcode[1:0] != 2'b11) begin
            iclass = CLS_ILLEGAL;
        end else begin
            case (opcode)
                OPC_OP:       iclass = CLS_OP;
                OPC_OP_IMM:   iclass = is_shift_f3(f3) ? CLS_OPIMM_SH : CLS_OPIMM;
                OPC_LUI:      iclass = CLS_LUI;
                OPC_AUIPC:    iclass = CLS_AUIPC;
                OPC_JAL:      iclass = CLS_JAL;
                OPC_JALR:     iclass = CLS_JALR;
                OPC_BRANCH:   iclass = CLS_BRANCH;
                OPC_LOAD:     iclass = CLS_LOAD;
                OPC_STORE:    iclass = CLS_STORE;
                OPC_MISC_MEM: iclass = CLS_FENCE;
                OPC_SYSTEM:   iclass = is_halting_system_f3(f3) ? CLS_ILLEGAL : CLS_CSR;
                default:      iclass = CLS_ILLEGAL;
            endcase
        end
    end

    assign illegal = (iclass == CLS_ILLEGAL);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM (FETCH/EXEC/MEM/HALT) driving datapath strobes and selects.
module control_unit
    import control_unit_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_complete,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    output logic       write_pc,
    output logic       write_pc_ne,
    output logic       write_pc_ex,
    output logic       write_ir,
    output logic       write_rd,
    output logic       write_csr,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic [1:0] rd_sel,
    output logic [1:0] alu_insel1,
    output logic [1:0] alu_insel2,
    output logic       illegal
);

    state_t  state;
    logic    mem_is_store;
    iclass_t iclass;
    logic    dec_illegal;

    control_decode u_decode (
        .opcode  (opcode),
        .f3      (f3),
        .iclass  (iclass),
        .illegal (dec_illegal)
    );

    // State register; the load/store direction is latched on entry to MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RESET_STATE;
            mem_is_store <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_complete) state <= EXEC;
                end
                EXEC: begin
                    if (dec_illegal) begin
                        state <= HALT;
                    end else if ((iclass == CLS_LOAD) || (iclass == CLS_STORE)) begin
                        state        <= MEM;
                        mem_is_store <= (iclass == CLS_STORE);
                    end else begin
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (mem_complete) state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= RESET_STATE;
            endcase
        end
    end

    // Output decode; reset forces everything low so an in-flight request is dropped at once.
    always_comb begin
        write_pc_ne = 1'b0;
        write_pc_ex = 1'b0;
        write_ir    = 1'b0;
        write_rd    = 1'b0;
        write_csr   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr_sel    = ADDR_ALU;
        rd_sel      = RD_ALU;
        alu_insel1  = ALU1_RS;
        alu_insel2  = ALU2_RS;
        illegal     = 1'b0;
        if (rst) begin
            illegal = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    mem_read = 1'b1;
                    addr_sel = ADDR_PC;
                    write_ir = mem_complete;
                end
                EXEC: begin
                    case (iclass)
                        CLS_OP: begin
                            write_rd    = 1'b1;
                            write_pc_ne = 1'b1;
                        end
                        CLS_OPIMM, CLS_OPIMM_SH: begin
                            alu_insel2  = (iclass == CLS_OPIMM_SH) ? ALU2_IS : ALU2_IM;
                            write_rd    = 1'b1;
                            write_pc_ne = 1'b1;
                        end
                        CLS_LUI, CLS_AUIPC: begin
                            alu_insel1  = (iclass == CLS_LUI) ? ALU1_ZR : ALU1_PC;
                            alu_insel2  = ALU2_IM;
                            write_rd    = 1'b1;
                            write_pc_ne = 1'b1;
                        end
                        CLS_JAL, CLS_JALR: begin
                            alu_insel1  = (iclass == CLS_JAL) ? ALU1_PC : ALU1_RS;
                            alu_insel2  = ALU2_IM;
                            rd_sel      = RD_NPC;
                            write_rd    = 1'b1;
                            write_pc_ex = 1'b1;
                        end
                        CLS_BRANCH: begin
                            alu_insel1  = ALU1_PC;
                            alu_insel2  = ALU2_IM;
                            write_pc_ne = 1'b1;
                            write_pc_ex = 1'b1;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_insel2 = ALU2_IM;
                        end
                        CLS_FENCE: begin
                            write_pc_ne = 1'b1;
                        end
                        CLS_CSR: begin
                            rd_sel      = RD_CSR;
                            write_csr   = 1'b1;
                            write_rd    = 1'b1;
                            write_pc_ne = 1'b1;
                        end
                        default: begin
                            write_pc_ne = 1'b0;
                        end
                    endcase
                end
                MEM: begin
                    addr_sel   = ADDR_ALU;
                    alu_insel2 = ALU2_IM;
                    mem_read   = ~mem_is_store;
                    mem_write  = mem_is_store;
                    if (mem_complete) begin
                        write_pc_ne = 1'b1;
                        write_rd    = ~mem_is_store;
                        rd_sel      = mem_is_store ? RD_ALU : RD_MEM;
                    end else begin
                        write_pc_ne = 1'b0;
                    end
                end
                HALT: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

    assign write_pc = write_pc_ne | write_pc_ex;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: random instruction streams compared cycle by cycle against a transaction-level model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_complete = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] f3 = 3'd0;
    logic       write_pc, write_pc_ne, write_pc_ex, write_ir, write_rd, write_csr;
    logic       mem_read, mem_write, addr_sel, illegal;
    logic [1:0] rd_sel, alu_insel1, alu_insel2;

    int passed = 0;
    int total  = 0;

    logic [6:0] op_tab [0:12];

    control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .mem_complete (mem_complete),
        .opcode       (opcode),
        .f3           (f3),
        .write_pc     (write_pc),
        .write_pc_ne  (write_pc_ne),
        .write_pc_ex  (write_pc_ex),
        .write_ir     (write_ir),
        .write_rd     (write_rd),
        .write_csr    (write_csr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .addr_sel     (addr_sel),
        .rd_sel       (rd_sel),
        .alu_insel1   (alu_insel1),
        .alu_insel2   (alu_insel2),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {illegal, write_pc, write_pc_ne, write_pc_ex, write_ir, write_rd, write_csr,
                  mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2};

    // Expected output word; write_pc is always the OR of the two PC strobes.
    function automatic logic [15:0] pack_out(input bit ill, input bit ne, input bit ex, input bit ir,
                                             input bit rd, input bit csr, input bit mrd, input bit mwr,
                                             input bit asel, input logic [1:0] rsel,
                                             input logic [1:0] a1, input logic [1:0] a2);
        return {ill, ne | ex, ne, ex, ir, rd, csr, mrd, mwr, asel, rsel, a1, a2};
    endfunction

    // Expected EXEC-cycle outputs, straight from the instruction table (RS=0 PC=1 ZR=2; RS=0 IM=1 IS=2).
    function automatic logic [15:0] exp_exec(input logic [6:0] op, input logic [2:0] fn);
        case (op)
            7'b0110011: return pack_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
            7'b0010011: return pack_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                                        (fn == 3'd1 || fn == 3'd5) ? 2'd2 : 2'd1);
            7'b0110111: return pack_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1);
            7'b0010111: return pack_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1);
            7'b1101111: return pack_out(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1);
            7'b1100111: return pack_out(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd1);
            7'b1100011: return pack_out(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1);
            7'b0000011,
            7'b0100011: return pack_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1);
            7'b0001111: return pack_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
            7'b1110011: begin
                if (fn == 3'd0 || fn == 3'd4) return 16'h0000;
                return pack_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0);
            end
            default:    return 16'h0000;
        endcase
    endfunction

    function automatic bit halts(input logic [6:0] op, input logic [2:0] fn);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0001111: return 1'b0;
            7'b1110011: return (fn == 3'd0 || fn == 3'd4);
            default:    return 1'b1;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else passed++;
    endtask

    task automatic fetch_phase(input int fw);
        for (int i = 0; i <= fw; i++) begin
            @(negedge clk);
            mem_complete = (i == fw);
            opcode = 7'($urandom);
            f3 = 3'($urandom);
            #1;
            check_eq("fetch", obs, pack_out(1'b0, 1'b0, 1'b0, (i == fw), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                            2'd0, 2'd0, 2'd0));
        end
    endtask

    task automatic exec_phase(input logic [6:0] op, input logic [2:0] fn);
        @(negedge clk);
        opcode = op;
        f3 = fn;
        mem_complete = 1'($urandom);
        #1;
        check_eq("exec", obs, exp_exec(op, fn));
    endtask

    task automatic mem_phase(input bit is_load, input int mw);
        for (int i = 0; i <= mw; i++) begin
            @(negedge clk);
            mem_complete = (i == mw);
            #1;
            check_eq(is_load ? "mem_load" : "mem_store", obs,
                     pack_out(1'b0, (i == mw), 1'b0, 1'b0, (i == mw) && is_load, 1'b0, is_load, !is_load,
                              1'b0, ((i == mw) && is_load) ? 2'd1 : 2'd0, 2'd0, 2'd1));
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] fn, input int fw, input int mw,
                             output bit halted);
        fetch_phase(fw);
        exec_phase(op, fn);
        halted = halts(op, fn);
        if (!halted && (op == 7'b0000011 || op == 7'b0100011)) mem_phase(op == 7'b0000011, mw);
    endtask

    task automatic check_halt(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_complete = 1'($urandom);
            opcode = 7'($urandom);
            f3 = 3'($urandom);
            #1;
            check_eq("halt", obs, pack_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           2'd0, 2'd0, 2'd0));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_complete = 1'($urandom);
        #1;
        check_eq("reset_assert", obs, 16'h0000);
        @(negedge clk);
        mem_complete = 1'b1;
        #1;
        check_eq("reset_hold", obs, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        mem_complete = 1'b0;
        #1;
        check_eq("reset_release", obs, pack_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                                2'd0, 2'd0, 2'd0));
    endtask

    initial begin
        bit halted;
        int k;
        op_tab = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                   7'b0000011, 7'b0100011, 7'b0001111, 7'b1110011, 7'b1111111, 7'b0110000};

        do_reset();

        run_instr(7'b0010011, 3'b000, 2, 0, halted);
        run_instr(7'b0010011, 3'b101, 0, 0, halted);
        run_instr(7'b0000011, 3'b010, 1, 3, halted);
        run_instr(7'b0100011, 3'b010, 0, 0, halted);
        run_instr(7'b1110011, 3'b001, 1, 0, halted);

        fetch_phase(1);
        exec_phase(7'b0000011, 3'b010);
        @(negedge clk);
        mem_complete = 1'b0;
        #1;
        check_eq("mem_before_abort", obs, pack_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                                   2'd0, 2'd0, 2'd1));
        do_reset();

        run_instr(7'b1111111, 3'b000, 0, 0, halted);
        check_halt(10);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 13);
            run_instr((k == 13) ? 7'($urandom) : op_tab[k], 3'($urandom),
                      $urandom_range(0, 4), $urandom_range(0, 4), halted);
            if (halted) begin
                check_halt(3);
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
